// File: rtl/key_router_pkg.sv
// Shared keycodes, held-mask bit positions and state encodings for key_router.
package key_router_pkg;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  // Held mask layout {U,L,D,R,F}
  localparam int BIT_U = 4;
  localparam int BIT_L = 3;
  localparam int BIT_D = 2;
  localparam int BIT_R = 1;
  localparam int BIT_F = 0;

  typedef enum logic [1:0] {IDLE, FIRING, WAIT_REL} fire_state_t;
  typedef enum logic [2:0] {MV_NONE, MV_U, MV_L, MV_D, MV_R} mv_t;

  // Movement priority is U > D > L > R.
  function automatic mv_t pick_mv(input logic [4:0] mask);
    if (mask[BIT_U])      return MV_U;
    else if (mask[BIT_D]) return MV_D;
    else if (mask[BIT_L]) return MV_L;
    else if (mask[BIT_R]) return MV_R;
    else                  return MV_NONE;
  endfunction

  function automatic logic mv_held(input mv_t mv, input logic [4:0] mask);
    case (mv)
      MV_U:    return mask[BIT_U];
      MV_L:    return mask[BIT_L];
      MV_D:    return mask[BIT_D];
      MV_R:    return mask[BIT_R];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/key_router_player.sv
// Per-player decode: held mask, most-recent movement tracking, fire stretch FSM, output code.
module key_player_decode
  import key_router_pkg::*;
#(
  parameter logic [7:0]  CODE_U      = KEY_W,
  parameter logic [7:0]  CODE_L      = KEY_A,
  parameter logic [7:0]  CODE_D      = KEY_S,
  parameter logic [7:0]  CODE_R      = KEY_D,
  parameter logic [7:0]  CODE_F      = KEY_SPACE,
  parameter int unsigned FIRE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  logic [31:0] report,
  input  logic        frame_tick,
  output logic [7:0]  code,
  output logic [7:0]  code_next
);

  localparam int CNT_W = (FIRE_FRAMES > 1) ? $clog2(FIRE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FIRE_FRAMES - 1);

  logic [3:0][4:0]  slot_hit;
  logic [4:0]       held, new_mask;
  logic [4:0]       held_prev_reg, held_prev_next;
  mv_t              mv_reg, mv_next;
  fire_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             f_held;

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign slot_hit[gi][BIT_U] = (report[gi*8 +: 8] == CODE_U);
    assign slot_hit[gi][BIT_L] = (report[gi*8 +: 8] == CODE_L);
    assign slot_hit[gi][BIT_D] = (report[gi*8 +: 8] == CODE_D);
    assign slot_hit[gi][BIT_R] = (report[gi*8 +: 8] == CODE_R);
    assign slot_hit[gi][BIT_F] = (report[gi*8 +: 8] == CODE_F);
  end

  // OR across slots makes a code repeated in several slots count once.
  assign held     = slot_hit[0] | slot_hit[1] | slot_hit[2] | slot_hit[3];
  assign new_mask = held & ~held_prev_reg;
  assign f_held   = accept ? held[BIT_F] : held_prev_reg[BIT_F];

  always_comb begin
    held_prev_next = held_prev_reg;
    mv_next        = mv_reg;
    state_next     = state_reg;
    cnt_next       = cnt_reg;

    if (accept) begin
      held_prev_next = held;
      if (|new_mask[4:1])
        mv_next = pick_mv(new_mask);
      else if (mv_reg != MV_NONE && !mv_held(mv_reg, held))
        mv_next = pick_mv(held);
    end

    // A fire entering FIRING this cycle ignores a coincident tick.
    case (state_reg)
      IDLE: begin
        if (accept && new_mask[BIT_F]) begin
          state_next = FIRING;
          cnt_next   = '0;
        end
      end
      FIRING: begin
        if (frame_tick) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = f_held ? WAIT_REL : IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      WAIT_REL: begin
        if (accept && !held[BIT_F])
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    code_next = 8'h00;
    if (state_next == FIRING) begin
      code_next = CODE_F;
    end else begin
      case (mv_next)
        MV_U:    code_next = CODE_U;
        MV_L:    code_next = CODE_L;
        MV_D:    code_next = CODE_D;
        MV_R:    code_next = CODE_R;
        default: code_next = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_prev_reg <= '0;
      mv_reg        <= MV_NONE;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      code          <= 8'h00;
    end else begin
      held_prev_reg <= held_prev_next;
      mv_reg        <= mv_next;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      code          <= code_next;
    end
  end

endmodule

// File: rtl/key_router.sv
// HID report router to the two tank-game player codes. Optional report
// debounce is compiled in with KEY_ROUTER_DEBOUNCE_EN.
module key_router
  import key_router_pkg::*;
#(
  parameter int unsigned FIRE_FRAMES      = 2,
  parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        report_valid,
  input  logic [31:0] report,
  input  logic        frame_tick,
  output logic [7:0]  keycode,
  output logic [7:0]  keycode2,
  output logic        key_event
);

  logic       accept;
  logic [7:0] keycode_next, keycode2_next;

  if (FIRE_FRAMES < 1 || DEBOUNCE_SAMPLES < 1) begin : g_bad_params
    $error("key_router: FIRE_FRAMES and DEBOUNCE_SAMPLES must be at least 1");
  end

`ifdef KEY_ROUTER_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [DB_W-1:0] DB_FULL = DB_W'(DEBOUNCE_SAMPLES);

  logic [31:0]     db_report_reg;
  logic [DB_W-1:0] db_cnt_reg, db_cnt_next;

  // Run length of identical strobes, saturating so a held report keeps being accepted.
  always_comb begin
    db_cnt_next = db_cnt_reg;
    if (report_valid) begin
      if (report == db_report_reg && db_cnt_reg != '0)
        db_cnt_next = (db_cnt_reg == DB_FULL) ? db_cnt_reg : db_cnt_reg + 1'b1;
      else
        db_cnt_next = DB_W'(1);
    end
  end

  assign accept = report_valid && (db_cnt_next == DB_FULL);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      db_report_reg <= '0;
      db_cnt_reg    <= '0;
    end else if (report_valid) begin
      db_report_reg <= report;
      db_cnt_reg    <= db_cnt_next;
    end
  end
`else
  assign accept = report_valid;
`endif

  key_player_decode #(
    .CODE_U(KEY_W), .CODE_L(KEY_A), .CODE_D(KEY_S), .CODE_R(KEY_D),
    .CODE_F(KEY_SPACE), .FIRE_FRAMES(FIRE_FRAMES)
  ) u_p1 (
    .clk(Clk), .rst_n(Reset_n), .accept(accept), .report(report),
    .frame_tick(frame_tick), .code(keycode), .code_next(keycode_next)
  );

  key_player_decode #(
    .CODE_U(KEY_UP), .CODE_L(KEY_LEFT), .CODE_D(KEY_DOWN), .CODE_R(KEY_RIGHT),
    .CODE_F(KEY_ENTER), .FIRE_FRAMES(FIRE_FRAMES)
  ) u_p2 (
    .clk(Clk), .rst_n(Reset_n), .accept(accept), .report(report),
    .frame_tick(frame_tick), .code(keycode2), .code_next(keycode2_next)
  );

  // Compare against the next codes so the pulse lines up with the new value.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      key_event <= 1'b0;
    else
      key_event <= (keycode_next != keycode) || (keycode2_next != keycode2);
  end

endmodule

// File: tb/tb_key_router.sv
// Directed self-checking bench for key_router (FIRE_FRAMES=2, DEBOUNCE_SAMPLES=3).
module tb_key_router;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        report_valid = 1'b0;
  logic [31:0] report = '0;
  logic        frame_tick = 1'b0;
  logic [7:0]  keycode, keycode2;
  logic        key_event;

  int errors = 0;
  int checks = 0;

`ifdef KEY_ROUTER_DEBOUNCE_EN
  localparam int REPS = 3;
`else
  localparam int REPS = 1;
`endif

  key_router #(.FIRE_FRAMES(2), .DEBOUNCE_SAMPLES(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .report_valid(report_valid), .report(report),
    .frame_tick(frame_tick), .keycode(keycode), .keycode2(keycode2), .key_event(key_event)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Called #1 after a rising edge; applies inputs for one full cycle.
  task automatic step(input logic rv, input logic [31:0] rep, input logic ft);
    report_valid = rv;
    report       = rep;
    frame_tick   = ft;
    @(posedge Clk);
    #1;
    report_valid = 1'b0;
    frame_tick   = 1'b0;
  endtask

  task automatic send(input logic [31:0] rep, input logic ft);
    for (int i = 0; i < REPS - 1; i++) step(1'b1, rep, 1'b0);
    step(1'b1, rep, ft);
  endtask

  task automatic tick();
    step(1'b0, report, 1'b1);
  endtask

  task automatic outs(input string tag, input logic [7:0] k1, input logic [7:0] k2, input logic ev);
    chk({tag, ".keycode"},   {24'h0, keycode},  {24'h0, k1});
    chk({tag, ".keycode2"},  {24'h0, keycode2}, {24'h0, k2});
    chk({tag, ".key_event"}, {31'h0, key_event}, {31'h0, ev});
  endtask

  initial begin
    #3;
    outs("reset", 8'h00, 8'h00, 1'b0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    step(1'b0, '0, 1'b0);

    // Most-recent movement wins, fallback on release
    send(32'h0000_001A, 1'b0); outs("w", 8'h1A, 8'h00, 1'b1);
    send(32'h0000_071A, 1'b0); outs("w+d", 8'h07, 8'h00, 1'b1);
    send(32'h0000_001A, 1'b0); outs("d_rel", 8'h1A, 8'h00, 1'b1);
    send(32'h0000_0000, 1'b0); outs("empty", 8'h00, 8'h00, 1'b1);
    send(32'h0707_0707, 1'b0); outs("dup_slots", 8'h07, 8'h00, 1'b1);
    send(32'h0000_0000, 1'b0); outs("empty2", 8'h00, 8'h00, 1'b1);

    // Independent players; identical resend causes no event
    send(32'h0000_521A, 1'b0); outs("both", 8'h1A, 8'h52, 1'b1);
    send(32'h0000_521A, 1'b0); outs("resend", 8'h1A, 8'h52, 1'b0);
    send(32'h0000_0000, 1'b0); outs("clear", 8'h00, 8'h00, 1'b1);

    // Fire stretch for two ticks, no re-fire while held
    send(32'h0000_2C1A, 1'b0); outs("fire", 8'h2C, 8'h00, 1'b1);
    step(1'b0, report, 1'b0);  outs("fire_idle", 8'h2C, 8'h00, 1'b0);
    tick();                    outs("fire_t1", 8'h2C, 8'h00, 1'b0);
    tick();                    outs("fire_t2", 8'h1A, 8'h00, 1'b1);
    send(32'h0000_2C1A, 1'b0); outs("fire_held", 8'h1A, 8'h00, 1'b0);
    tick();                    outs("held_tick", 8'h1A, 8'h00, 1'b0);
    send(32'h0000_001A, 1'b0); outs("fire_rel", 8'h1A, 8'h00, 1'b0);
    send(32'h0000_2C1A, 1'b0); outs("refire", 8'h2C, 8'h00, 1'b1);
    tick(); tick();            outs("refire_end", 8'h1A, 8'h00, 1'b1);

    // Release during FIRING is not truncated
    send(32'h0000_0000, 1'b0); outs("rel_all", 8'h00, 8'h00, 1'b1);
    send(32'h0000_002C, 1'b0); outs("fire2", 8'h2C, 8'h00, 1'b1);
    send(32'h0000_0000, 1'b0); outs("fire2_rel", 8'h2C, 8'h00, 1'b0);
    tick();                    outs("fire2_t1", 8'h2C, 8'h00, 1'b0);
    tick();                    outs("fire2_t2", 8'h00, 8'h00, 1'b1);

    // Report and tick in the same cycle: the tick is not counted
    send(32'h0000_0028, 1'b1); outs("sim", 8'h00, 8'h28, 1'b1);
    tick();                    outs("sim_t1", 8'h00, 8'h28, 1'b0);
    tick();                    outs("sim_t2", 8'h00, 8'h00, 1'b1);

    // Unrecognized code is ignored
    send(32'h0000_0000, 1'b0);
    send(32'h0000_001A, 1'b0); outs("pre_ign", 8'h1A, 8'h00, 1'b1);
    send(32'h0000_101A, 1'b0); outs("ignored", 8'h1A, 8'h00, 1'b0);

    // Asynchronous reset mid-stream, then first-report behaviour
    send(32'h0000_0000, 1'b0);
    send(32'h0000_2C1A, 1'b0);
    tick(); tick();            outs("pre_rst", 8'h1A, 8'h00, 1'b1);
    #1 Reset_n = 1'b0;
    #1;                        outs("async_rst", 8'h00, 8'h00, 1'b0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    send(32'h0000_2C1A, 1'b0); outs("post_rst", 8'h2C, 8'h00, 1'b1);
    tick(); tick();
    send(32'h0000_0000, 1'b0); outs("post_rst_clr", 8'h00, 8'h00, 1'b1);

`ifdef KEY_ROUTER_DEBOUNCE_EN
    // A, A, B, B, B: only the completed run of B is accepted
    step(1'b1, 32'h0000_001A, 1'b0);
    step(1'b1, 32'h0000_001A, 1'b0); outs("db_a2", 8'h00, 8'h00, 1'b0);
    step(1'b1, 32'h0000_0007, 1'b0);
    step(1'b1, 32'h0000_0007, 1'b0); outs("db_b2", 8'h00, 8'h00, 1'b0);
    step(1'b1, 32'h0000_0007, 1'b0); outs("db_b3", 8'h07, 8'h00, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
